// File: rtl/pipelined_rv_exec_core.sv
// Two-stage RV32 R/I-type ALU core: ID latches and decodes the instruction, W holds
// the result until the downstream consumer takes it, and the register file is written at retire.
module pipelined_rv_exec_core #(
    parameter int unsigned XLEN = 16,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [RA_W-1:0] out_rd,
    output logic            out_illegal,
    output logic [15:0]     retire_cnt
);
    localparam int unsigned NREG  = 2 ** RA_W;
    localparam logic [6:0]  OpReg = 7'b0110011;
    localparam logic [6:0]  OpImm = 7'b0010011;

    logic            id_valid_q;
    logic [31:0]     id_instr_q;
    logic            w_valid_q;
    logic            w_we_q;
    logic            w_illegal_q;
    logic [XLEN-1:0] w_data_q;
    logic [RA_W-1:0] w_rd_q;
    logic [15:0]     retire_cnt_q;
    logic [XLEN-1:0] rf_q [NREG];

    logic            advance;
    logic            accept;
    logic            retire;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            alt;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] op2;
    logic [4:0]      shamt;
    logic            shamt_ovf;
    logic [XLEN-1:0] result;
    logic            legal;
    logic            unused_instr;

    assign advance  = !w_valid_q || out_ready;
    assign in_ready = advance || !id_valid_q;
    assign accept   = in_valid && in_ready;
    assign retire   = w_valid_q && out_ready;

    assign opcode       = id_instr_q[6:0];
    assign rd           = id_instr_q[7 +: RA_W];
    assign funct3       = id_instr_q[14:12];
    assign rs1          = id_instr_q[15 +: RA_W];
    assign rs2          = id_instr_q[20 +: RA_W];
    assign alt          = id_instr_q[30];
    assign imm          = XLEN'($signed(id_instr_q[31:20]));
    // Upper register-index bits are ignored when RA_W < 5.
    assign unused_instr = ^id_instr_q;

    // Operand read with bypass from the not-yet-retired W result.
    always_comb begin
        op1 = rf_q[rs1];
        if (w_valid_q && w_we_q && (rs1 != '0) && (w_rd_q == rs1)) begin
            op1 = w_data_q;
        end
        rs2_val = rf_q[rs2];
        if (w_valid_q && w_we_q && (rs2 != '0) && (w_rd_q == rs2)) begin
            rs2_val = w_data_q;
        end
    end

    assign op2       = (opcode == OpImm) ? imm : rs2_val;
    assign shamt     = op2[4:0];
    assign shamt_ovf = 32'(shamt) >= XLEN;

    always_comb begin
        result = '0;
        legal  = 1'b1;
        if ((opcode == OpReg) || (opcode == OpImm)) begin
            case (funct3)
                3'b000: result = ((opcode == OpReg) && alt) ? op1 - op2 : op1 + op2;
                3'b111: result = op1 & op2;
                3'b110: result = op1 | op2;
                3'b100: result = op1 ^ op2;
                3'b001: result = shamt_ovf ? '0 : op1 << shamt;
                3'b101: begin
                    if (shamt_ovf) begin
                        result = (alt && op1[XLEN-1]) ? '1 : '0;
                    end else if (alt) begin
                        result = $signed(op1) >>> shamt;
                    end else begin
                        result = op1 >> shamt;
                    end
                end
                default: legal = 1'b0;
            endcase
        end else begin
            legal = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q   <= 1'b0;
            id_instr_q   <= '0;
            w_valid_q    <= 1'b0;
            w_we_q       <= 1'b0;
            w_illegal_q  <= 1'b0;
            w_data_q     <= '0;
            w_rd_q       <= '0;
            retire_cnt_q <= '0;
        end else begin
            if (accept) begin
                id_valid_q <= 1'b1;
                id_instr_q <= in_instr;
            end else if (advance) begin
                id_valid_q <= 1'b0;
            end
            if (advance) begin
                w_valid_q   <= id_valid_q;
                w_data_q    <= (id_valid_q && legal) ? result : '0;
                w_rd_q      <= rd;
                w_illegal_q <= id_valid_q && !legal;
                w_we_q      <= id_valid_q && legal && (rd != '0);
            end
            if (retire) begin
                retire_cnt_q <= retire_cnt_q + 16'd1;
            end
        end
    end

    // Register 0 is never written because w_we_q excludes rd == 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (retire && w_we_q) begin
            rf_q[w_rd_q] <= w_data_q;
        end
    end

    assign out_valid   = w_valid_q;
    assign out_data    = w_data_q;
    assign out_rd      = w_rd_q;
    assign out_illegal = w_illegal_q;
    assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_pipelined_rv_exec_core.sv
// Bench for pipelined_rv_exec_core: directed scenarios plus random traffic, all scored
// against an in-order architectural model with an expected-retirement queue.
module tb_pipelined_rv_exec_core;
    localparam int unsigned XLEN  = 16;
    localparam int unsigned RA_W  = 5;
    localparam int          NREG  = 1 << RA_W;
    localparam logic [63:0] XMASK = (XLEN == 64) ? '1 : ((64'd1 << XLEN) - 64'd1);

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic [RA_W-1:0] out_rd;
    logic            out_illegal;
    logic [15:0]     retire_cnt;

    pipelined_rv_exec_core #(
        .XLEN(XLEN),
        .RA_W(RA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .out_illegal(out_illegal),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        ill;
        int          k;
    } exp_t;

    exp_t        q[$];
    logic [63:0] mreg [NREG];
    logic [15:0] mcnt;
    int          cyc;
    int          nvec;
    int          nerr;
    logic        last_acc;
    logic [63:0] last_data;
    logic [4:0]  last_rd;
    logic        last_ill;
    logic [15:0] cnt_before;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NREG; i++) mreg[i] = '0;
        mcnt = '0;
    endtask

    // Sequential ISA semantics: each instruction sees every earlier one's effect.
    task automatic ref_exec(input logic [31:0] ins, output exp_t e);
        logic [63:0] a, b, r;
        logic [6:0]  opc;
        logic [2:0]  f3;
        int          rd, rs1, rs2, sh;
        logic        ok;
        opc = ins[6:0];
        f3  = ins[14:12];
        rd  = int'(ins[11:7]) % NREG;
        rs1 = int'(ins[19:15]) % NREG;
        rs2 = int'(ins[24:20]) % NREG;
        a   = mreg[rs1];
        b   = (opc == 7'h13) ? ({{52{ins[31]}}, ins[31:20]} & XMASK) : mreg[rs2];
        sh  = int'(b[4:0]);
        ok  = ((opc == 7'h33) || (opc == 7'h13)) && (f3 != 3'b010) && (f3 != 3'b011);
        r   = '0;
        if (ok) begin
            case (f3)
                3'd0: r = ((opc == 7'h33) && ins[30]) ? a - b : a + b;
                3'd7: r = a & b;
                3'd6: r = a | b;
                3'd4: r = a ^ b;
                3'd1: r = (sh >= int'(XLEN)) ? 64'd0 : a << sh;
                3'd5: begin
                    if (sh >= int'(XLEN)) begin
                        r = (ins[30] && a[XLEN-1]) ? XMASK : 64'd0;
                    end else begin
                        r = a >> sh;
                        if (ins[30] && a[XLEN-1]) r |= XMASK & ~(XMASK >> sh);
                    end
                end
                default: ;
            endcase
        end
        r &= XMASK;
        if (ok && rd != 0) mreg[rd] = r;
        e.data = r;
        e.rd   = rd[4:0];
        e.ill  = !ok;
        e.k    = 0;
    endtask

    // One clock: sample at the falling edge, score, then move to just after the rising edge.
    task automatic step();
        int   n;
        exp_t e;
        @(negedge clk);
        n = q.size();
        check_eq("in_ready", in_ready, !(n == 2 && !out_ready));
        // Accepted at edge k -> held in W after edge k+1, retirable at edge k+2.
        check_eq("out_valid", out_valid, (n > 0) && (cyc >= q[0].k + 1));
        check_eq("retire_cnt", retire_cnt, mcnt);
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (n == 0) begin
                check_eq("spurious_retire", out_valid, 1'b0);
            end else begin
                e = q.pop_front();
                check_eq("out_data", out_data, e.data);
                check_eq("out_rd", out_rd, e.rd);
                check_eq("out_illegal", out_illegal, e.ill);
                mcnt++;
            end
            last_data = out_data;
            last_rd   = out_rd;
            last_ill  = out_illegal;
        end
        if (last_acc) begin
            ref_exec(in_instr, e);
            e.k = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [31:0] ins);
        in_valid = 1'b1;
        in_instr = ins;
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_acc) break;
        end
        if (!last_acc) check_eq("issue_timeout", last_acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        if (q.size() != 0) check_eq("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        int          kind;
        kind = $urandom_range(0, 9);
        f3   = 3'($urandom);
        rd   = 5'($urandom_range(0, 7));
        rs1  = 5'($urandom_range(0, 7));
        rs2  = 5'($urandom_range(0, 7));
        if (kind < 4)      w = {1'b0, 1'($urandom), 5'b0, rs2, rs1, f3, rd, 7'b0110011};
        else if (kind < 9) w = {12'($urandom), rs1, f3, rd, 7'b0010011};
        else               w = $urandom;
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] pend[$];
        nvec = 0;
        nerr = 0;
        cyc  = 0;
        last_acc  = 1'b0;
        last_data = '0;
        last_rd   = '0;
        last_ill  = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        model_reset();

        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_data", out_data, 64'd0);
        check_eq("rst_out_rd", out_rd, 64'd0);
        check_eq("rst_out_illegal", out_illegal, 1'b0);
        check_eq("rst_retire_cnt", retire_cnt, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_release_in_ready", in_ready, 1'b1);

        // Back-to-back with forwarding.
        out_ready = 1'b1;
        issue(32'h00500093);
        issue(32'h00308113);
        issue(32'h002081B3);
        drain();
        check_eq("fwd_add_x3", last_data, 64'd13);
        check_eq("fwd_retire_cnt", retire_cnt, 64'd3);

        issue(32'h40100233);
        drain();
        check_eq("sub_data", last_data, 64'hFFFB);
        check_eq("sub_rd", last_rd, 64'd4);

        issue(32'h00700013);
        drain();
        check_eq("x0_addi_data", last_data, 64'd7);
        issue(32'h000002B3);
        drain();
        check_eq("x0_reads_zero", last_data, 64'd0);

        // Backpressure: three offered while the consumer stalls.
        cnt_before = retire_cnt;
        pend = '{32'h00100493, 32'h00148493, 32'h00148493};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = (pend.size() > 0);
            in_instr = (pend.size() > 0) ? pend[0] : 32'h0;
            step();
            if (last_acc) void'(pend.pop_front());
            if (i == 1) check_eq("stall_in_ready_low", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && pend.size() > 0; i++) begin
            in_valid = 1'b1;
            in_instr = pend[0];
            step();
            if (last_acc) void'(pend.pop_front());
        end
        drain();
        check_eq("stall_last_x9", last_data, 64'd3);
        check_eq("stall_retired", retire_cnt - cnt_before, 64'd3);

        // Illegal instruction retires without touching x31.
        cnt_before = retire_cnt;
        issue(32'hFFFFFFFF);
        drain();
        check_eq("ill_flag", last_ill, 1'b1);
        check_eq("ill_data", last_data, 64'd0);
        check_eq("ill_retire_cnt", retire_cnt, 64'(cnt_before + 16'd1));
        issue(32'h000F8433);
        drain();
        check_eq("ill_x31_unchanged", last_data, 64'd0);

        // Reset while W is stalled holding ADDI x6.
        out_ready = 1'b0;
        issue(32'h00900313);
        step();
        check_eq("pre_rst_w_full", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", out_valid, 1'b0);
        check_eq("midrst_out_data", out_data, 64'd0);
        check_eq("midrst_retire_cnt", retire_cnt, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        check_eq("post_rst_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        issue(32'h000303B3);
        drain();
        check_eq("post_rst_x6_zero", last_data, 64'd0);
        check_eq("post_rst_rd", last_rd, 64'd7);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
